// File: rtl/fuzzy_phase_sequencer_if.sv
// Handshake/bus bundle between the sequencer and its controller/datapath.
// master drives subclk/start/samples/clr_ovr; slave (the sequencer) drives status and enables.
interface fuzzy_phase_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        subclk;
    logic              start;
    logic [DATA_W-1:0] err_in;
    logic [DATA_W-1:0] derr_in;
    logic              clr_ovr;
    logic              ready;
    logic              busy;
    logic [3:0]        stage_en;
    logic [DATA_W-1:0] err_q;
    logic [DATA_W-1:0] derr_q;
    logic              done;
    logic              overrun;
    logic              timeout;

    modport master (
        output subclk, start, err_in, derr_in, clr_ovr,
        input  ready, busy, stage_en, err_q, derr_q, done, overrun, timeout
    );

    modport slave (
        input  subclk, start, err_in, derr_in, clr_ovr,
        output ready, busy, stage_en, err_q, derr_q, done, overrun, timeout
    );
endinterface

// File: rtl/fuzzy_phase_sequencer.sv
// Steps one fuzzy evaluation ARM->FUZZ->RULE->AGG->DEFUZZ, one stage per rising edge of subclk[TICK_SEL].
// Latency: acceptance to done is 4P+1..5P cycles (P = 2^(4-TICK_SEL)); all outputs registered.
// Backpressure: start is taken only while ready; a start while busy is dropped and flags overrun. SEQ_WATCHDOG_EN adds a stall abort.
module fuzzy_phase_sequencer #(
    parameter int DATA_W      = 8,
    parameter int TICK_SEL    = 0,
    parameter int WDOG_CYCLES = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    fuzzy_phase_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_FUZZ, S_RULE, S_AGG, S_DEFUZZ} state_t;

    if (TICK_SEL < 0 || TICK_SEL > 3 || WDOG_CYCLES < 2) begin : g_bad_param
        $error("fuzzy_phase_sequencer: illegal TICK_SEL or WDOG_CYCLES");
    end

    state_t            state_q, state_d;
    logic              prev_q, prev_d;
    logic              tick;
    logic              ready_q, ready_d;
    logic [3:0]        stage_en_q, stage_en_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] err_q, err_d;
    logic [DATA_W-1:0] derr_q, derr_d;
    logic              wdog_expire;

    assign prev_d = bus.subclk[TICK_SEL];
    assign tick   = bus.subclk[TICK_SEL] & ~prev_q;

`ifdef SEQ_WATCHDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES) + 1;
    logic [CNT_W-1:0] wdog_q, wdog_d;

    // Counts cycles since the last tick; only meaningful outside IDLE.
    assign wdog_expire = (state_q != S_IDLE) && !tick && (wdog_q == CNT_W'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_d = wdog_q + 1'b1;
        if (state_q == S_IDLE || tick || wdog_expire) begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        derr_d    = derr_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        overrun_d = overrun_q;
        if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (bus.start && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end
        if (wdog_expire) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A tick coincident with acceptance is deliberately not consumed.
                    if (bus.start) begin
                        state_d = S_ARM;
                        err_d   = bus.err_in;
                        derr_d  = bus.derr_in;
                    end
                end
                S_ARM:    if (tick) state_d = S_FUZZ;
                S_FUZZ:   if (tick) state_d = S_RULE;
                S_RULE:   if (tick) state_d = S_AGG;
                S_AGG:    if (tick) state_d = S_DEFUZZ;
                S_DEFUZZ: begin
                    if (tick) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default:  state_d = S_IDLE;
            endcase
        end

        ready_d = (state_d == S_IDLE);
        case (state_d)
            S_FUZZ:   stage_en_d = 4'b0001;
            S_RULE:   stage_en_d = 4'b0010;
            S_AGG:    stage_en_d = 4'b0100;
            S_DEFUZZ: stage_en_d = 4'b1000;
            default:  stage_en_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prev_q     <= 1'b1;
            ready_q    <= 1'b1;
            stage_en_q <= 4'b0000;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= '0;
            derr_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            ready_q    <= ready_d;
            stage_en_q <= stage_en_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
            derr_q     <= derr_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = ~ready_q;
    assign bus.stage_en = stage_en_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;
    assign bus.timeout  = timeout_q;
    assign bus.err_q    = err_q;
    assign bus.derr_q   = derr_q;
endmodule

// File: tb/tb_fuzzy_phase_sequencer.sv
// Bench for fuzzy_phase_sequencer: free-running divider drives subclk, random starts feed a
// tick-count reference model whose predicted operations are checked by a negedge monitor.
`timescale 1ns/1ps
module tb_fuzzy_phase_sequencer;
    localparam int DATA_W   = 8;
    localparam int TICK_SEL = 2;
    localparam int WDOG     = 64;
    localparam int P        = 1 << (4 - TICK_SEL);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fuzzy_phase_sequencer_if #(.DATA_W(DATA_W)) bus ();

    fuzzy_phase_sequencer #(
        .DATA_W(DATA_W), .TICK_SEL(TICK_SEL), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Subclock divider: subclk[i] toggles every 2^(3-i) cycles.
    int         cyc;
    logic [3:0] div_q;
    logic       freeze = 1'b0;
    logic [3:0] frz_val = 4'h0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc   <= 0;
            div_q <= 4'h0;
        end else begin
            cyc   <= cyc + 1;
            div_q <= div_q + 4'h1;
        end
    end
    always @* bus.subclk = freeze ? frz_val : {div_q[0], div_q[1], div_q[2], div_q[3]};

    // Edge e (cyc==e after it) samples divider value e-1: rising select bit at (e-1)%P == P/2.
    function automatic bit is_tick_edge(input int e);
        return (e >= 2) && (((e - 1) % P) == P / 2);
    endfunction

    function automatic int first_tick_after(input int n);
        for (int e = n + 1; e <= n + P + 1; e++) begin
            if (is_tick_edge(e)) return e;
        end
        return n + P;
    endfunction

    typedef struct {
        int                n;
        int                t1;
        logic [DATA_W-1:0] err;
        logic [DATA_W-1:0] derr;
    } op_t;

    op_t               sbq[$];
    bit                have_op = 1'b0;
    int                cur_t5 = 0;
    bit                exp_ovr = 1'b0;
    logic [DATA_W-1:0] last_err = '0;
    logic [DATA_W-1:0] last_derr = '0;
    bit                mon_en = 1'b0;

    function automatic bit model_busy_at(input int e);
        return have_op && (e <= cur_t5);
    endfunction

    // Reference model: an accepted start yields done at the 5th tick after acceptance.
    always @(posedge clk) begin
        if (rst_n) begin
            int  e;
            bit  bsy;
            op_t o;
            e   = cyc + 1;
            bsy = model_busy_at(e);
            if (bus.start && !bsy) begin
                o.n    = e;
                o.t1   = first_tick_after(e);
                o.err  = bus.err_in;
                o.derr = bus.derr_in;
                sbq.push_back(o);
                have_op = 1'b1;
                cur_t5  = o.t1 + 4 * P;
            end
            if (bus.start && bsy) exp_ovr = 1'b1;
            else if (bus.clr_ovr) exp_ovr = 1'b0;
        end
    end

    // Monitor: compares DUT outputs with the head of the scoreboard every cycle.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            int                c, es, t5;
            bit                ed, erdy;
            logic [DATA_W-1:0] xe, xd;
            c = cyc; es = 0; ed = 1'b0; erdy = 1'b1; xe = last_err; xd = last_derr;
            if (sbq.size() > 0) begin
                xe = sbq[0].err;
                xd = sbq[0].derr;
                t5 = sbq[0].t1 + 4 * P;
                if (c < t5) begin
                    erdy = 1'b0;
                    if (c >= sbq[0].t1) es = 1 << ((c - sbq[0].t1) / P);
                end else begin
                    ed = 1'b1;
                end
            end
            chk("stage_en", int'(bus.stage_en), es);
            chk("done", int'(bus.done), int'(ed));
            chk("ready", int'(bus.ready), int'(erdy));
            chk("busy", int'(bus.busy), int'(!erdy));
            chk("overrun", int'(bus.overrun), int'(exp_ovr));
            chk("timeout", int'(bus.timeout), 0);
            chk("err_q", int'(bus.err_q), int'(xe));
            chk("derr_q", int'(bus.derr_q), int'(xd));
            if ((ed || bus.done) && sbq.size() > 0) begin
                last_err  = xe;
                last_derr = xd;
                void'(sbq.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        bus.start = 1'b0; bus.clr_ovr = 1'b0; bus.err_in = '0; bus.derr_in = '0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        sbq.delete();
        have_op = 1'b0; cur_t5 = 0; exp_ovr = 1'b0; last_err = '0; last_derr = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (model_busy_at(cyc + 1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("wait_idle_bound", 1, 0);
    endtask

    task automatic wait_cyc(input int target);
        int k;
        k = 0;
        while (cyc < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("wait_cyc_reached", cyc, target);
    endtask

    task automatic pulse_start(input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] d);
        bus.start = 1'b1; bus.err_in = e; bus.derr_in = d;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t1;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_stage_en", int'(bus.stage_en), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        chk("rst_err_q", int'(bus.err_q), 0);
        chk("rst_derr_q", int'(bus.derr_q), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal evaluation.
        wait_idle();
        pulse_start(8'h12, 8'hF0);
        wait_idle();

        // Randomized traffic: starts (often while busy), clears and random samples.
        for (int i = 0; i < 1500; i++) begin
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.clr_ovr = ($urandom_range(0, 9) == 0);
            bus.err_in  = DATA_W'($urandom);
            bus.derr_in = DATA_W'($urandom);
            @(negedge clk);
        end
        idle_inputs();
        wait_idle();

        // Start coincident with a tick: ARM must last a full period.
        for (int r = 0; r < 3; r++) begin
            wait_idle();
            for (int k = 0; k < P + 1 && !is_tick_edge(cyc + 1); k++) @(negedge clk);
            pulse_start(DATA_W'($urandom), DATA_W'($urandom));
        end
        wait_idle();

        // Overrun during RULE, then clear together with a busy start, then clear alone.
        bus.clr_ovr = 1'b1;
        @(negedge clk);
        bus.clr_ovr = 1'b0;
        pulse_start(8'h5A, 8'hA5);
        wait_cyc(cur_t5 - 3 * P);
        bus.start = 1'b1; bus.err_in = 8'hEE; bus.derr_in = 8'hDD;
        @(negedge clk);
        bus.clr_ovr = 1'b1;
        @(negedge clk);
        idle_inputs();
        wait_idle();
        bus.clr_ovr = 1'b1;
        @(negedge clk);
        bus.clr_ovr = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of RULE.
        pulse_start(8'h33, 8'h44);
        wait_cyc(cur_t5 - 3 * P);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_stage_en", int'(bus.stage_en), 0);
        chk("midrst_ready", int'(bus.ready), 1);
        chk("midrst_err_q", int'(bus.err_q), 0);
        chk("midrst_derr_q", int'(bus.derr_q), 0);
        chk("midrst_done", int'(bus.done), 0);
        do_reset();
        repeat (3 * P) @(negedge clk);

        // Frozen subclk while in FUZZ.
        wait_idle();
        pulse_start(8'h77, 8'h88);
        t1 = cur_t5 - 4 * P;
        wait_cyc(t1);
        mon_en  = 1'b0;
        frz_val = bus.subclk;
        freeze  = 1'b1;
        repeat (WDOG - 1) @(negedge clk);
        chk("frz_stage_hold", int'(bus.stage_en), 1);
        chk("frz_timeout_early", int'(bus.timeout), 0);
        @(negedge clk);
`ifdef SEQ_WATCHDOG_EN
        chk("wdog_timeout", int'(bus.timeout), 1);
        chk("wdog_stage_en", int'(bus.stage_en), 0);
        chk("wdog_ready", int'(bus.ready), 1);
        chk("wdog_done", int'(bus.done), 0);
        @(negedge clk);
        chk("wdog_timeout_pulse", int'(bus.timeout), 0);
`else
        chk("nowdog_timeout", int'(bus.timeout), 0);
        chk("nowdog_stage_en", int'(bus.stage_en), 1);
        chk("nowdog_ready", int'(bus.ready), 0);
        repeat (20) @(negedge clk);
        chk("nowdog_still_fuzz", int'(bus.stage_en), 1);
`endif
        freeze = 1'b0;
        do_reset();
        wait_idle();
        pulse_start(8'hC3, 8'h3C);
        wait_idle();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fuzzy_phase_sequencer.md
# fuzzy_phase_sequencer

Sequences one fuzzy-controller evaluation through its four stages: fuzzify, rule evaluation, aggregation and defuzzify. It sits directly downstream of the subclock divider and consumes its 4-bit `subclk` phase vector. A rising edge on one selected phase becomes a single-cycle tick, and each tick advances the pipeline by one stage. The block latches the input sample on a start handshake and drives one-hot stage enables to the fuzzy datapath.

## Interface
- `DATA_W`, default 8: width of the error and delta-error samples.
- `TICK_SEL`, default 0, legal range 0..3: index of the `subclk` bit used as the tick source. The tick period is 2^(4-TICK_SEL) clk cycles.
- `WDOG_CYCLES`, default 64: watchdog limit in clk cycles. Used only when `SEQ_WATCHDOG_EN` is defined.
- `clk` in, 1: system clock; all logic is clocked on the posedge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `subclk` in, 4: phase vector from the subclock divider, synchronous to `clk`.
- `start` in, 1: request to evaluate the current sample.
- `err_in` in, DATA_W: error sample.
- `derr_in` in, DATA_W: delta-error sample.
- `clr_ovr` in, 1: clears `overrun`.
- `ready` out, 1: high while in IDLE.
- `busy` out, 1: equal to `~ready`.
- `stage_en` out, 4: one-hot stage enable. bit0 = FUZZ, bit1 = RULE, bit2 = AGG, bit3 = DEFUZZ.
- `err_q` out, DATA_W: latched error sample.
- `derr_q` out, DATA_W: latched delta-error sample.
- `done` out, 1: one-cycle completion pulse.
- `overrun` out, 1: sticky flag, set when `start` arrives while busy.
- `timeout` out, 1: one-cycle watchdog abort pulse.

## Operation
- **Tick generation.**
  - `prev` is a register holding `subclk[TICK_SEL]` from the previous cycle; its reset value is 1.
  - `tick = subclk[TICK_SEL] & ~prev`, combinational.
  - With the reset value of 1, no tick can occur in the first cycle after reset.
- **States:** IDLE, ARM, FUZZ, RULE, AGG, DEFUZZ. State encoding is free.
- **IDLE.**
  - When `start`=1, the start is accepted: `err_in` and `derr_in` are latched into `err_q` and `derr_q`, and the FSM goes to ARM.
  - A tick arriving in the same cycle as an accepted start is not consumed.
  - Ticks in IDLE are ignored.
- **Stage progression.** Each tick advances exactly one state: ARM → FUZZ → RULE → AGG → DEFUZZ → IDLE. With no tick, the FSM holds its state.
- **Stage enables.** `stage_en` is registered. It holds the one-hot code for the whole duration of its state and is 0 in IDLE and ARM.
- **Completion.** The tick that leaves DEFUZZ sets `done`=1 for exactly one cycle, coinciding with the first IDLE cycle.
- **Held samples.** `err_q` and `derr_q` are held from acceptance until the next accepted start.
- **Overrun.**
  - `start`=1 in any state other than IDLE is ignored and sets `overrun`.
  - `clr_ovr` clears `overrun`.
  - If set and clear occur in the same cycle, set wins.
- **Reset.**
  - All outputs reset to 0 except `ready`, which resets to 1.
  - `err_q` and `derr_q` reset to 0.
  - Asserting `rst_n` in the middle of an operation aborts to IDLE immediately, without a `done` pulse.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- **Acceptance.** With `start` sampled at edge N, the following are visible after edge N:
  - `ready`=0;
  - `err_q` and `derr_q` updated.
- **Stage-enable latency.** The k-th tick after acceptance is at edge T_k, counting ticks from edge N+1 onward.
  - `stage_en` changes after edge T_1 to FUZZ, after T_2 to RULE, after T_3 to AGG, and after T_4 to DEFUZZ.
  - After T_5, `stage_en`=0 and `done`=1 for one cycle, and `ready`=1.
- **Stage duration.** Each stage lasts exactly one tick period P = 2^(4-TICK_SEL) cycles.
- **Latency bound.** Total latency from acceptance to `done` is between 4P+1 and 5P cycles.
- **Back-to-back operation.** A new `start` may be accepted in the same cycle that `done`=1.

## Configuration
- **Macro:** `SEQ_WATCHDOG_EN`.
- **Defined.**
  - A cycle counter runs in every non-IDLE state.
  - The counter is cleared on every tick and held at 0 in IDLE.
  - When it reaches `WDOG_CYCLES`-1 with no tick, the FSM aborts to IDLE:
    - `timeout`=1 for one cycle;
    - `stage_en`=0;
    - no `done` pulse;
    - `overrun` is unaffected.
- **Undefined.** The counter is absent, `timeout` is tied to 0, and the FSM waits for ticks indefinitely.

## Test plan
- **Nominal evaluation.** Divider-driven `subclk`, TICK_SEL=3 (P=2); pulse `start` with `err_in`=0x12 and `derr_in`=0xF0 → `err_q`=0x12 and `derr_q`=0xF0. `stage_en` steps 1, 2, 4, 8, each held 2 cycles. `done` is a single pulse between 9 and 10 cycles after acceptance.
- **Slow tick.** TICK_SEL=0 (P=16) → each `stage_en` value is held exactly 16 cycles and `done` occurs 65 to 80 cycles after acceptance.
- **Overrun and clear.** Pulse `start` while `stage_en`=2 → `overrun`=1, `err_q` unchanged, sequence completes normally. Assert `clr_ovr` together with a second busy `start` → `overrun` stays 1. `clr_ovr` alone → `overrun`=0.
- **Start and tick coincident.** `start` in the same cycle as a tick in IDLE → the FSM enters ARM, not FUZZ, and FUZZ starts on the following tick.
- **Reset mid-operation.** Drop `rst_n` during RULE → immediately `stage_en`=0, `ready`=1, `err_q`=0, and no `done` pulse.
- **Watchdog abort.** With `SEQ_WATCHDOG_EN` defined and `WDOG_CYCLES`=64, freeze `subclk` in FUZZ → after 64 cycles without a tick, `timeout` pulses once, `stage_en`=0 and `ready`=1. Without the macro, the FSM stays in FUZZ and `timeout` stays 0.
